// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// One operation in flight: IDLE -> EXEC (one ALU cycle) -> RESP (hold until taken).
module alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_x,
  output logic             rsp_zero,
  output logic             rsp_sign,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_x,
  input  logic             alu_zero,
  input  logic             alu_sign,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q;
  logic             ptr_q;
  logic             owner_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] rsp_x_q;
  logic             rsp_zero_q;
  logic             rsp_sign_q;
  logic             rsp0_valid_q;
  logic             rsp1_valid_q;
  logic             busy_q;
  logic             grant;
  logic             rsp_hs;

  // A lone requester wins outright; on contention the pointer picks the one not served last.
  always_comb begin
    grant = ptr_q;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (!req0_valid && req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state_q == StIdle) && req0_valid && !grant;
  assign req1_ready = (state_q == StIdle) && req1_valid && grant;

  // Only the owner's rsp_ready can complete the response.
  assign rsp_hs = (rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ptr_q        <= 1'b0;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      rsp_x_q      <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_sign_q   <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req0_ready || req1_ready) begin
            a_q     <= grant ? req1_a : req0_a;
            b_q     <= grant ? req1_b : req0_b;
            op_q    <= grant ? req1_op : req0_op;
            owner_q <= grant;
            ptr_q   <= !grant;
            busy_q  <= 1'b1;
            state_q <= StExec;
          end
        end
        StExec: begin
          rsp_x_q      <= alu_x;
          rsp_zero_q   <= alu_zero;
          rsp_sign_q   <= alu_sign;
          rsp0_valid_q <= !owner_q;
          rsp1_valid_q <= owner_q;
          state_q      <= StResp;
        end
        StResp: begin
          if (rsp_hs) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rsp_x      = rsp_x_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_sign   = rsp_sign_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with an adder ALU stub (X=A+B).
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [5:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp_x, alu_a, alu_b, alu_x;
  logic        rsp_zero, rsp_sign, alu_zero, alu_sign, busy;
  logic [5:0]  alu_op;

  typedef struct {
    int          owner;
    logic [31:0] x;
    logic        z;
    logic        s;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   mdl_ptr = 0;
  int   cyc = 0;
  int   both_ready_cnt = 0;
  int   ready_busy_cnt = 0;

  always #5 clk = ~clk;

  assign alu_x    = alu_a + alu_b;
  assign alu_zero = (alu_x == 32'h0);
  assign alu_sign = alu_x[31];

  alu_arbiter #(.WIDTH(32), .OPW(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_x(rsp_x), .rsp_zero(rsp_zero), .rsp_sign(rsp_sign),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_x(alu_x), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .busy(busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_ready && req1_ready) both_ready_cnt <= both_ready_cnt + 1;
      if (busy && (req0_ready || req1_ready)) ready_busy_cnt <= ready_busy_cnt + 1;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    mdl_ptr = 0;
  endtask

  task automatic drive(input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] op);
    if (p == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  // Waits for a request handshake, pushes the modelled result, steps past the accepting edge.
  task automatic wait_accept(input bit keep, output bit ok, output int who, output int n);
    exp_t        e;
    logic [31:0] s;
    ok = 1'b0; who = -1; n = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) begin
        who = 0; ok = 1'b1;
      end else if (req1_valid && req1_ready) begin
        who = 1; ok = 1'b1;
      end
    end
    if (ok) begin
      s = (who == 1) ? req1_a + req1_b : req0_a + req0_b;
      e.owner = who; e.x = s; e.z = (s == 32'h0); e.s = s[31];
      exp_q.push_back(e);
      n = cyc;
      mdl_ptr = 1 - who;
      @(posedge clk);
      #1;
      if (!keep) begin
        if (who == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
      end
    end
  endtask

  task automatic wait_rsp(output bit ok, output int n);
    ok = 1'b0; n = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) begin
        ok = 1'b1; n = cyc;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000",
               {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready});
    else n_pass++;
    n_checks++;
    if ({rsp_x, rsp_zero, rsp_sign} !== 34'h0)
      $display("FAIL reset_rsp: got %h %b %b want 0", rsp_x, rsp_zero, rsp_sign);
    else n_pass++;
    n_checks++;
    if ({alu_a, alu_b, alu_op} !== 70'h0)
      $display("FAIL reset_alu: got %h %h %h want 0", alu_a, alu_b, alu_op);
    else n_pass++;
  endtask

  task automatic test_single();
    bit ok; int who, na, nr;
    exp_t e;
    @(posedge clk); #1;
    drive(0, 32'd1234, 32'd5678, 6'd0);
    wait_accept(1'b0, ok, who, na);
    n_checks++;
    if (!ok || who != 0) $display("FAIL single_accept: got ok=%0d who=%0d want 1/0", ok, who);
    else n_pass++;
    wait_rsp(ok, nr);
    n_checks++;
    if (!ok || nr != na + 2) $display("FAIL single_latency: got %0d want %0d", nr - na, 2);
    else n_pass++;
    n_checks++;
    if (!ok || exp_q.size() == 0) $display("FAIL single_rsp: no response");
    else begin
      e = exp_q.pop_front();
      if ({rsp1_valid, rsp0_valid, rsp_x, rsp_zero, rsp_sign} !==
          {e.owner == 1, e.owner == 0, e.x, e.z, e.s})
        $display("FAIL single_rsp: got v=%b%b x=%h z=%b s=%b want owner %0d x=%h",
                 rsp1_valid, rsp0_valid, rsp_x, rsp_zero, rsp_sign, e.owner, e.x);
      else n_pass++;
    end
    n_checks++;
    if ({rsp_x, rsp_zero, rsp_sign, rsp1_valid} !== {32'd6912, 3'b000})
      $display("FAIL single_value: got %0d %b %b %b want 6912 0 0 0",
               rsp_x, rsp_zero, rsp_sign, rsp1_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({rsp0_valid, busy, rsp_x} !== {2'b00, 32'd6912})
      $display("FAIL single_retain: got v=%b busy=%b x=%0d want 0 0 6912",
               rsp0_valid, busy, rsp_x);
    else n_pass++;
  endtask

  task automatic test_contention();
    bit ok; int who, na, nr;
    exp_t e;
    do_reset();
    drive(0, 32'd1, 32'd2, 6'd0);
    drive(1, 32'h82345671, 32'h0, 6'd0);
    for (int k = 0; k < 2; k++) begin
      wait_accept(1'b0, ok, who, na);
      n_checks++;
      if (!ok || who != k) $display("FAIL contend_grant%0d: got %0d want %0d", k, who, k);
      else n_pass++;
      wait_rsp(ok, nr);
      n_checks++;
      if (!ok || exp_q.size() == 0) $display("FAIL contend_rsp%0d: no response", k);
      else begin
        e = exp_q.pop_front();
        if ({rsp1_valid, rsp0_valid, rsp_x, rsp_zero, rsp_sign} !==
            {e.owner == 1, e.owner == 0, e.x, e.z, e.s})
          $display("FAIL contend_rsp%0d: got x=%h s=%b want x=%h s=%b",
                   k, rsp_x, rsp_sign, e.x, e.s);
        else n_pass++;
      end
    end
    n_checks++;
    if (rsp_sign !== 1'b1 || rsp_x !== 32'h82345671)
      $display("FAIL contend_req1: got x=%h s=%b want 82345671 1", rsp_x, rsp_sign);
    else n_pass++;
    n_checks++;
    if (both_ready_cnt != 0) $display("FAIL both_ready: got %0d want 0", both_ready_cnt);
    else n_pass++;
  endtask

  task automatic test_fairness();
    bit ok; int who, na, nr, want;
    int cnt[2];
    exp_t e;
    cnt[0] = 0; cnt[1] = 0;
    @(posedge clk); #1;
    drive(0, $urandom, $urandom, 6'd1);
    drive(1, $urandom, $urandom, 6'd2);
    for (int k = 0; k < 12; k++) begin
      want = mdl_ptr;
      wait_accept(1'b1, ok, who, na);
      n_checks++;
      if (!ok || who != want) $display("FAIL fair_grant%0d: got %0d want %0d", k, who, want);
      else n_pass++;
      if (ok) begin
        cnt[who]++;
        drive(who, $urandom, $urandom, 6'(k));
      end
      wait_rsp(ok, nr);
      n_checks++;
      if (!ok || exp_q.size() == 0) $display("FAIL fair_rsp%0d: no response", k);
      else begin
        e = exp_q.pop_front();
        if ({rsp1_valid, rsp0_valid, rsp_x, rsp_zero, rsp_sign} !==
            {e.owner == 1, e.owner == 0, e.x, e.z, e.s})
          $display("FAIL fair_rsp%0d: got x=%h want x=%h owner %0d", k, rsp_x, e.x, e.owner);
        else n_pass++;
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++;
    if (cnt[0] != 6 || cnt[1] != 6) $display("FAIL fair_count: got %0d/%0d want 6/6", cnt[0], cnt[1]);
    else n_pass++;
    n_checks++;
    if (ready_busy_cnt != 0) $display("FAIL ready_busy: got %0d want 0", ready_busy_cnt);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok; int who, na, nr;
    exp_t e;
    @(posedge clk); #1;
    rsp1_ready = 1'b0;
    drive(1, 32'h7000_0001, 32'h1000_0000, 6'd3);
    wait_accept(1'b0, ok, who, na);
    drive(0, 32'd9, 32'd9, 6'd0);
    wait_rsp(ok, nr);
    n_checks++;
    if (!ok || exp_q.size() == 0) begin
      $display("FAIL bp_rsp: no response");
    end else begin
      e = exp_q.pop_front();
      n_pass++;
      for (int i = 0; i < 5; i++) begin
        if (i > 0) @(negedge clk);
        n_checks++;
        if ({rsp1_valid, rsp0_valid, rsp_x, rsp_zero, rsp_sign, busy, req0_ready} !==
            {e.owner == 1, e.owner == 0, e.x, e.z, e.s, 2'b10})
          $display("FAIL bp_hold%0d: got v=%b%b x=%h busy=%b rdy0=%b want v=10 x=%h busy=1 rdy0=0",
                   i, rsp1_valid, rsp0_valid, rsp_x, busy, req0_ready, e.x);
        else n_pass++;
      end
    end
    @(posedge clk); #1;
    rsp1_ready = 1'b1;
    req0_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rsp1_valid !== 1'b1) $display("FAIL bp_release: got rsp1_valid=%b want 1", rsp1_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({busy, rsp1_valid} !== 2'b00)
      $display("FAIL bp_idle: got busy=%b rsp1_valid=%b want 0 0", busy, rsp1_valid);
    else n_pass++;
  endtask

  task automatic test_zero();
    bit ok; int who, na, nr;
    exp_t e;
    @(posedge clk); #1;
    drive(0, 32'hFFFF_FFFF, 32'd1, 6'd0);
    wait_accept(1'b0, ok, who, na);
    wait_rsp(ok, nr);
    n_checks++;
    if (!ok || exp_q.size() == 0) $display("FAIL zero_rsp: no response");
    else begin
      e = exp_q.pop_front();
      if ({rsp0_valid, rsp_x, rsp_zero, rsp_sign} !== {e.owner == 0, e.x, e.z, e.s} ||
          {rsp_x, rsp_zero, rsp_sign} !== {32'h0, 2'b10})
        $display("FAIL zero_rsp: got x=%h z=%b s=%b want 0 1 0", rsp_x, rsp_zero, rsp_sign);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_op();
    bit ok; int who, na, nr;
    exp_t e;
    @(posedge clk); #1;
    drive(1, 32'd5, 32'd6, 6'd0);
    wait_accept(1'b0, ok, who, na);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    mdl_ptr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, rsp0_valid, rsp1_valid, rsp_x} !== 35'h0)
        $display("FAIL midrst_%0d: got busy=%b v=%b%b x=%h want all 0",
                 i, busy, rsp1_valid, rsp0_valid, rsp_x);
      else n_pass++;
    end
    @(posedge clk); #1;
    drive(0, 32'd40, 32'd2, 6'd0);
    drive(1, 32'd50, 32'd3, 6'd0);
    wait_accept(1'b0, ok, who, na);
    n_checks++;
    if (!ok || who != 0) $display("FAIL midrst_grant: got %0d want 0", who);
    else n_pass++;
    req1_valid = 1'b0;
    wait_rsp(ok, nr);
    n_checks++;
    if (!ok || exp_q.size() == 0) $display("FAIL midrst_rsp: no response");
    else begin
      e = exp_q.pop_front();
      if ({rsp1_valid, rsp0_valid, rsp_x, rsp_zero, rsp_sign} !==
          {e.owner == 1, e.owner == 0, e.x, e.z, e.s})
        $display("FAIL midrst_rsp: got x=%h want x=%h", rsp_x, e.x);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_zero();
    test_reset_mid_op();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width.
REQ-002 Parameter: OPW, 6, ALU opcode width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 req0_valid, req1_valid  in  1 each  requester i has an operation pending.
REQ-006 req0_ready, req1_ready  out  1 each  requester i's operation accepted this cycle.
REQ-007 req0_a, req0_b, req1_a, req1_b  in  WIDTH each  operands of requester i.
REQ-008 req0_op, req1_op  in  OPW each  ALU opcode of requester i.
REQ-009 rsp0_valid, rsp1_valid  out  1 each  result for requester i is presented.
REQ-010 rsp0_ready, rsp1_ready  in  1 each  requester i takes the result.
REQ-011 rsp_x  out  WIDTH  result, shared by both requesters.
REQ-012 rsp_zero, rsp_sign  out  1 each  flags, shared by both requesters.
REQ-013 alu_a, alu_b  out  WIDTH each  operands to the shared combinational ALU.
REQ-014 alu_op  out  OPW  opcode to the ALU.
REQ-015 alu_x  in  WIDTH  ALU result.
REQ-016 alu_zero, alu_sign  in  1 each  ALU flags.
REQ-017 busy  out  1  high while in EXEC or RESP.

Function
REQ-018 FSM states: IDLE, EXEC, RESP; transitions occur only on clk rising edge.
REQ-019 IDLE grant: if only one reqi_valid is high, grant that requester.
REQ-020 IDLE grant: if both are high, grant the requester not served last (round-robin pointer).
REQ-021 reqi_ready shall be combinational, high only when state is IDLE and requester i is granted; never high for both requesters.
REQ-022 Handshake (reqi_valid & reqi_ready): latch a, b, op and owner id into internal registers; set pointer to the other requester; go to EXEC.
REQ-023 alu_a, alu_b, alu_op shall be driven from the latched registers at all times, never combinationally from request inputs.
REQ-024 EXEC lasts exactly one cycle: at its end, capture alu_x, alu_zero, alu_sign into rsp_x, rsp_zero, rsp_sign; go to RESP.
REQ-025 RESP: rsp_valid of the owner only is high; rsp_x and flags are held stable until the response handshake.
REQ-026 Response handshake (owner's rspi_valid & rspi_ready): go to IDLE next cycle; the non-owner's rsp_ready is ignored.
REQ-027 Latency: request accepted in cycle N means rsp_valid is high in cycle N+2; maximum throughput is one operation per 3 cycles.
REQ-028 No request is accepted in EXEC or RESP, even when the response completes in the same cycle.
REQ-029 Deasserting reqi_valid before its handshake is legal; nothing is latched and the pointer is unchanged.
REQ-030 rsp_x and flags retain the last result after returning to IDLE.
REQ-031 All internal and output registers shall have explicit reset values (REQ-032); there are no X states.

Reset
REQ-032 rst_n low at a clock edge: state IDLE; pointer selects requester 0; latched operands, opcode, owner, rsp_x, rsp_zero, rsp_sign and busy all 0; rsp0_valid and rsp1_valid both 0.
REQ-033 Reset asserted in EXEC or RESP aborts the transaction: no response is issued, and rsp_valid is low from the cycle after the reset edge.
REQ-034 The first grant after reset, with both requesters valid, goes to requester 0.

Verification (bench ALU stub: X=A+B, Zero=(X==0), Sign=X[WIDTH-1])
REQ-035 Single request: req0 a=1234, b=5678, op=0 accepted in cycle N -> rsp0_valid high in cycle N+2, rsp_x=6912, zero=0, sign=0; rsp1_valid stays 0.
REQ-036 Contention after reset: both valid, req0 a=1 b=2, req1 a=32'h82345671 b=32'h0 -> req0 served first (rsp_x=3), then req1 (rsp_x=32'h82345671, sign=1); the two reqi_ready are never high together.
REQ-037 Fairness: both requesters held valid for 12 ops -> grants alternate 0,1,0,1...; each requester gets exactly 6 ops.
REQ-038 Backpressure: rsp1_ready held low for 5 cycles -> rsp1_valid, rsp_x and flags stable, no new request accepted, busy=1; IDLE is reached the cycle after rsp1_ready rises.
REQ-039 Zero flag: a=32'hFFFFFFFF, b=1 -> rsp_x=0, zero=1, sign=0.
REQ-040 Reset mid-op: rst_n low during EXEC -> next cycle busy=0, both rsp_valid=0, rsp_x=0; a fresh request then completes normally.
